// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// spi_flash_pkg : shared types and constants for the SPI boot-flash reader
// Rev 1.0
// ============================================================================
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        DONE     = 3'd4,
        FT_WAIT  = 3'd5
    } state_e;

    localparam logic [7:0] CMD_READ       = 8'h03;
    localparam int         FRAME_BITS     = 40;
    localparam int         DATA_START_BIT = 32;

    // CPU window offset folded onto the flash byte space, wrapping at 2^24
    function automatic logic [23:0] flash_offset(input logic [23:0] base,
                                                 input logic [11:0] win);
        return base + {12'h000, win};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_read_ctrl_bit_engine.sv
`default_nettype none
// ============================================================================
// spi_bit_engine : SCK divider, bit counter and 40-bit mode-0 frame shifter
// Rev 1.0
// ============================================================================
module spi_bit_engine
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [FRAME_BITS-1:0] i_frame,
    input  logic                  i_miso,
    output logic                  o_sck,
    output logic                  o_mosi,
    output logic                  o_done,
    output logic [7:0]            o_rx_byte
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic                  active_q, active_d;
    logic                  sck_q,    sck_d;
    logic [DW-1:0]         div_q,    div_d;
    logic [5:0]            bit_q,    bit_d;
    logic [FRAME_BITS-1:0] shreg_q,  shreg_d;
    logic [7:0]            rx_q,     rx_d;
    logic                  div_last;

    assign div_last = (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        rx_d     = rx_q;
        o_done   = 1'b0;
        if (i_abort) begin
            active_d = 1'b0;
            sck_d    = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            shreg_d  = '0;
        end else if (i_start) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            shreg_d  = i_frame;
        end else if (active_q) begin
            if (!div_last) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                    if (bit_q >= 6'(DATA_START_BIT)) begin
                        rx_d = {rx_q[6:0], i_miso};
                    end
                end else begin
                    sck_d = 1'b0;
                    if (bit_q == 6'(FRAME_BITS - 1)) begin
                        // Clearing the shifter parks MOSI low between frames
                        active_d = 1'b0;
                        bit_d    = '0;
                        shreg_d  = '0;
                        o_done   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            rx_q     <= 8'h00;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            rx_q     <= rx_d;
        end
    end

    assign o_sck     = sck_q;
    assign o_mosi    = shreg_q[FRAME_BITS-1];
    assign o_rx_byte = rx_q;

endmodule
`default_nettype wire

// File: rtl/spi_flash_read_ctrl.sv
`default_nettype none
// ============================================================================
// spi_flash_read_ctrl : stretches 6809 reads of the boot window into SPI
// READ transactions, yielding the flash to the FT2232 whenever it asks
// Rev 1.0
// ============================================================================
module spi_flash_read_ctrl
    import spi_flash_pkg::*;
#(
    parameter int          CLK_DIV    = 2,
    parameter logic [23:0] FLASH_BASE = 24'h000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_spi_ce,
    input  logic        i_rd,
    input  logic [15:0] i_address,
    input  logic        i_FT_CS,
    input  logic        i_spi_miso,
    output logic        o_spi_cs_n,
    output logic        o_spi_sck,
    output logic        o_spi_mosi,
    output logic        o_spi_oe,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_mrdy
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_e         state_q,  state_d;
    logic [1:0]     ft_sync_q, ft_sync_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic           served_q, served_d;
    logic [23:0]    addr_q,   addr_d;
    logic           cs_n_q,   cs_n_d;
    logic           oe_q,     oe_d;
    logic [7:0]     data_q,   data_d;
    logic           valid_q,  valid_d;

    logic           ft_own;
    logic           accept;
    logic           cnt_last;
    logic           eng_start;
    logic           eng_abort;
    logic           eng_done;
    logic [7:0]     eng_rx;

    // Sync flops reset low, so the FT2232 owns the flash until it is seen idle
    assign ft_own   = ~ft_sync_q[1];
    assign accept   = (state_q == IDLE) & i_spi_ce & i_rd & ~served_q & ~ft_own;
    assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));
    assign o_mrdy   = ~(i_spi_ce & i_rd & ~served_q);

    always_comb begin
        ft_sync_d = {ft_sync_q[0], i_FT_CS};
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        eng_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CS_SETUP;
                    cnt_d   = '0;
                    addr_d  = flash_offset(FLASH_BASE, i_address[11:0]);
                end
            end
            CS_SETUP: begin
                if (cnt_last) begin
                    state_d   = SHIFT;
                    eng_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (eng_done) begin
                    state_d = CS_HOLD;
                    cnt_d   = '0;
                end
            end
            CS_HOLD: begin
                if (cnt_last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            FT_WAIT: begin
                if (!ft_own) begin
                    state_d = CS_SETUP;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ft_own && (state_q != IDLE) && (state_q != FT_WAIT)) begin
            state_d   = FT_WAIT;
            eng_start = 1'b0;
        end
        eng_abort = (state_d == FT_WAIT);

        // Pin-facing outputs are decoded from the next state so they register cleanly
        cs_n_d  = ~((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
        oe_d    = ~ft_own;
        valid_d = (state_d == DONE);
        data_d  = valid_d ? eng_rx : data_q;

        if (!i_spi_ce) begin
            served_d = 1'b0;
        end else if (state_d == DONE) begin
            served_d = 1'b1;
        end else begin
            served_d = served_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ft_sync_q <= 2'b00;
            cnt_q     <= '0;
            served_q  <= 1'b0;
            addr_q    <= 24'h000000;
            cs_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ft_sync_q <= ft_sync_d;
            cnt_q     <= cnt_d;
            served_q  <= served_d;
            addr_q    <= addr_d;
            cs_n_q    <= cs_n_d;
            oe_q      <= oe_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_engine (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (eng_start),
        .i_abort   (eng_abort),
        .i_frame   ({CMD_READ, addr_q, 8'h00}),
        .i_miso    (i_spi_miso),
        .o_sck     (o_spi_sck),
        .o_mosi    (o_spi_mosi),
        .o_done    (eng_done),
        .o_rx_byte (eng_rx)
    );

    assign o_spi_cs_n   = cs_n_q;
    assign o_spi_oe     = oe_q;
    assign o_data       = data_q;
    assign o_data_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_read_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_flash_read_ctrl : scoreboard bench with a behavioural SPI flash
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_flash_read_ctrl;

    localparam int          CLK_DIV = 2;
    localparam logic [23:0] BASE    = 24'hFFFF00;
    localparam int          LAT     = 82 * CLK_DIV;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_ce = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] address = 16'h0000;
    logic        ft_cs = 1'b0;
    logic        miso = 1'b0;
    wire         cs_n, sck, mosi, oe, dv, mrdy;
    wire [7:0]   data;

    // Driver-owned controls
    logic want_reset = 1'b1, want_mrdy_low = 1'b0, want_released = 1'b0, want_quiet = 1'b0;
    logic timeout_flag = 1'b0, end_req = 1'b0;
    // Monitor-owned state
    int   checks = 0, errors = 0, done_cnt = 0, cyc = 0;
    int   cs_fall = 0, fbits = 0;
    logic cs_prev = 1'b1, sck_prev = 1'b0, dv_prev = 1'b0, rise_pending = 1'b0;
    logic mosi_nz = 1'b0, timeout_reported = 1'b0, end_done = 1'b0;
    logic [31:0] hdr = 32'h0;
    exp_t exp_q[$];

    spi_flash_read_ctrl #(.CLK_DIV(CLK_DIV), .FLASH_BASE(BASE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_ce(spi_ce), .i_rd(rd),
        .i_address(address), .i_FT_CS(ft_cs), .i_spi_miso(miso),
        .o_spi_cs_n(cs_n), .o_spi_sck(sck), .o_spi_mosi(mosi), .o_spi_oe(oe),
        .o_data(data), .o_data_valid(dv), .o_mrdy(mrdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash contents: an arbitrary but address-dependent byte pattern
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return {a[3:0], a[7:4]} ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] b;
        if (want_reset) begin
            chk("rst_cs_n", 32'(cs_n), 1);
            chk("rst_sck", 32'(sck), 0);
            chk("rst_mosi", 32'(mosi), 0);
            chk("rst_oe", 32'(oe), 0);
            chk("rst_data", 32'(data), 0);
            chk("rst_dv", 32'(dv), 0);
            chk("rst_mrdy", 32'(mrdy), 1);
        end else begin
            if (want_mrdy_low && !dv) chk("mrdy_low", 32'(mrdy), 0);
            if (want_released) begin
                chk("ft_oe", 32'(oe), 0);
                chk("ft_cs_n", 32'(cs_n), 1);
                chk("ft_sck", 32'(sck), 0);
            end
            if (want_quiet) begin
                chk("wr_cs_n", 32'(cs_n), 1);
                chk("wr_mrdy", 32'(mrdy), 1);
                chk("wr_dv", 32'(dv), 0);
            end
            if (cs_prev && !cs_n) begin
                cs_fall      = cyc;
                rise_pending = 1'b1;
            end
            if (sck && !sck_prev && rise_pending) begin
                chk("first_sck_rise", 32'(cyc - cs_fall), 32'(2 * CLK_DIV));
                rise_pending = 1'b0;
            end
            // Behavioural mode-0 flash: shift on SCK rise, present data after SCK fall
            if (cs_n || !oe) begin
                fbits   = 0;
                mosi_nz = 1'b0;
                miso    = 1'($urandom);
            end else if (sck && !sck_prev) begin
                if (fbits < 32) hdr = {hdr[30:0], mosi};
                else if (mosi) mosi_nz = 1'b1;
                fbits++;
                if (fbits == 32) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame at cycle %0d: header %0h, no read pending", cyc, hdr);
                    end else begin
                        chk("frame_cmd", 32'(hdr[31:24]), 32'h03);
                        chk("frame_addr", 32'(hdr[23:0]), 32'(exp_q[0].addr));
                    end
                end
                if (fbits == 40) chk("mosi_data_zero", 32'(mosi_nz), 0);
            end else if (!sck && sck_prev) begin
                if (fbits >= 32 && fbits < 40) begin
                    b    = fbyte(hdr[23:0]);
                    miso = b[39 - fbits];
                end else begin
                    miso = 1'($urandom);
                end
            end
            if (dv) begin
                chk("dv_pulse_width", 32'(dv_prev), 0);
                chk("mrdy_at_done", 32'(mrdy), 1);
                chk("cs_n_at_done", 32'(cs_n), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid at cycle %0d: data %0h, no read pending", cyc, data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", 32'(data), 32'(e.data));
                    chk("latency", 32'(cyc - cs_fall), 32'(LAT));
                end
                done_cnt++;
            end
            if (timeout_flag && !timeout_reported) begin
                checks++;
                errors++;
                $display("FAIL timeout at cycle %0d: got no o_data_valid, expected one", cyc);
                timeout_reported = 1'b1;
            end
            if (end_req && !end_done) begin
                chk("queue_drained", 32'(exp_q.size()), 0);
                end_done = 1'b1;
            end
        end
        cs_prev  = cs_n;
        sck_prev = sck;
        dv_prev  = dv;
    end

    // ft_at < 0: no FT takeover; ft_at == 0: FT already owns the flash
    task automatic do_read(input logic [15:0] a, input int ft_at, input int ft_len, input int drop_at);
        exp_t e;
        int   start_done;
        logic got;
        e.addr = BASE + {12'h000, a[11:0]};
        e.data = fbyte(e.addr);
        exp_q.push_back(e);
        start_done = done_cnt;
        @(posedge clk);
        #1;
        spi_ce = 1'b1; rd = 1'b1; address = a; want_mrdy_low = 1'b1;
        if (ft_at == 0) want_released = 1'b1;
        got = 1'b0;
        for (int k = 1; k <= 3000 && !got; k++) begin
            @(posedge clk);
            if (done_cnt != start_done) got = 1'b1;
            #1;
            if (k == ft_at) ft_cs = 1'b0;
            if (ft_at >= 0 && k == ft_at + 3) want_released = 1'b1;
            if (ft_at >= 0 && k == ft_at + ft_len) begin
                ft_cs = 1'b1;
                want_released = 1'b0;
            end
            if (k == drop_at) begin
                spi_ce = 1'b0; rd = 1'b0; want_mrdy_low = 1'b0;
            end
        end
        spi_ce = 1'b0; rd = 1'b0; want_mrdy_low = 1'b0; want_released = 1'b0;
        ft_cs = 1'b1;
        if (!got) timeout_flag = 1'b1;
    endtask

    initial begin
        logic [15:0] a;
        repeat (3) @(posedge clk);
        #1;
        want_reset = 1'b0;
        rst_n      = 1'b1;

        // FT2232 holds the flash across reset release
        do_read(16'hF123, 0, 40, -1);

        // Write into the window is ignored
        @(posedge clk); #1;
        spi_ce = 1'b1; rd = 1'b0; address = 16'hF000; want_quiet = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        spi_ce = 1'b0; want_quiet = 1'b0;

        // Offset wrap boundaries around 2^24 with the high base
        do_read(16'hF0FF, -1, 0, -1);
        do_read(16'hF100, -1, 0, -1);
        do_read(16'hF1FF, -1, 0, -1);
        do_read(16'hFFFF, -1, 0, -1);

        // Back-to-back with a single-cycle chip-enable gap
        do_read(16'hF000, -1, 0, -1);
        do_read(16'hF001, -1, 0, -1);

        // FT takeover mid-read, then release and full restart
        do_read(16'hF456, 50, 100, -1);

        // Chip enable dropped mid-transaction
        do_read(16'hF789, -1, 0, 30);

        for (int i = 0; i < 10; i++) begin
            a = 16'hF000 | 16'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) == 0)
                do_read(a, int'($urandom_range(5, 150)), int'($urandom_range(20, 120)), -1);
            else
                do_read(a, -1, 0, -1);
        end

        repeat (5) @(posedge clk);
        #1;
        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
